// File: rtl/mira_ctrl.sv
// -----------------------------------------------------------------------------
// mira_ctrl : motion and fire controller for the crosshair sprite generator.
//
// Debounces the raw left/right/fire pushbuttons and paces crosshair movement
// against the video frame tick. Movement starts slow (one step every SLOW_DIV
// frames) and switches to one step per frame after HOLD_FRAMES frames of
// continuous hold. Fire produces one shot per press, followed by a frame-based
// cooldown and a mandatory release.
//
// Ports:
//   clk         system/pixel clock, single domain
//   nrst        synchronous active-low reset
//   btn_left    raw pushbutton, active-high, asynchronous
//   btn_right   raw pushbutton, active-high, asynchronous
//   btn_fire    raw pushbutton, active-high, asynchronous
//   frame_tick  one-cycle pulse per video frame
//   cnt_en      one-cycle step enable to the crosshair counter
//   updown      step direction, 1 = right (increment), 0 = left
//   shot        one-cycle fire pulse
//   fire_ready  high while the fire FSM is idle
// -----------------------------------------------------------------------------
module mira_ctrl #(
    parameter int DEB_CYCLES  = 250000,
    parameter int SLOW_DIV    = 4,
    parameter int HOLD_FRAMES = 30,
    parameter int COOL_FRAMES = 20
) (
    input  logic clk,
    input  logic nrst,
    input  logic btn_left,
    input  logic btn_right,
    input  logic btn_fire,
    input  logic frame_tick,
    output logic cnt_en,
    output logic updown,
    output logic shot,
    output logic fire_ready
);

    localparam int DEB_W = 18;
    localparam logic [DEB_W-1:0] DEB_LAST  = DEB_W'(DEB_CYCLES - 1);
    localparam logic [3:0]       DIV_LAST  = 4'(SLOW_DIV - 1);
    localparam logic [5:0]       HOLD_MAX  = 6'(HOLD_FRAMES);
    localparam logic [5:0]       COOL_LAST = 6'(COOL_FRAMES - 1);

    // Button vector order: [0] left, [1] right, [2] fire
    logic [2:0]            raw_s;
    logic [2:0]            sync1_r;
    logic [2:0]            sync2_r;
    logic [2:0]            deb_r;
    logic [2:0][DEB_W-1:0] deb_cnt_r;

    assign raw_s = {btn_fire, btn_right, btn_left};

    // Two-flop synchronizer for the asynchronous buttons
    always_ff @(posedge clk) begin
        if (!nrst) begin
            sync1_r <= 3'b000;
            sync2_r <= 3'b000;
        end else begin
            sync1_r <= raw_s;
            sync2_r <= sync1_r;
        end
    end

    // Per-button debounce: accept a change only after DEB_CYCLES consecutive disagreeing cycles
    always_ff @(posedge clk) begin
        if (!nrst) begin
            deb_r     <= 3'b000;
            deb_cnt_r <= {3{{DEB_W{1'b0}}}};
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (sync2_r[i] != deb_r[i]) begin
                    if (deb_cnt_r[i] == DEB_LAST) begin
                        deb_r[i]     <= sync2_r[i];
                        deb_cnt_r[i] <= {DEB_W{1'b0}};
                    end else begin
                        deb_cnt_r[i] <= deb_cnt_r[i] + DEB_W'(1);
                    end
                end else begin
                    deb_cnt_r[i] <= {DEB_W{1'b0}};
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Movement pacing
    // ------------------------------------------------------------------------
    logic       active_s;
    logic       dir_s;
    logic       step_s;
    logic [5:0] hold_r;
    logic [5:0] hold_nxt_s;
    logic [3:0] div_r;
    logic [3:0] div_nxt_s;
    logic       cnt_en_r;
    logic       updown_r;

    assign active_s = deb_r[0] ^ deb_r[1];
    assign dir_s    = deb_r[1];

    // Step decision and hold/divider update, evaluated only on a frame tick.
    // While a hold is in progress updown_r always equals the held direction,
    // so a mismatch means the player reversed without letting go.
    always_comb begin
        step_s     = 1'b0;
        hold_nxt_s = hold_r;
        div_nxt_s  = div_r;
        if (frame_tick) begin
            if (!active_s) begin
                hold_nxt_s = 6'd0;
                div_nxt_s  = 4'd0;
            end else if ((hold_r == 6'd0) || (dir_s != updown_r)) begin
                step_s     = 1'b1;
                hold_nxt_s = 6'd1;
                div_nxt_s  = 4'd0;
            end else if (hold_r >= HOLD_MAX) begin
                step_s     = 1'b1;
                div_nxt_s  = 4'd0;
            end else begin
                hold_nxt_s = hold_r + 6'd1;
                if (div_r == DIV_LAST) begin
                    step_s    = 1'b1;
                    div_nxt_s = 4'd0;
                end else begin
                    div_nxt_s = div_r + 4'd1;
                end
            end
        end else begin
            hold_nxt_s = hold_r;
            div_nxt_s  = div_r;
        end
    end

    // Movement state and registered step outputs
    always_ff @(posedge clk) begin
        if (!nrst) begin
            hold_r   <= 6'd0;
            div_r    <= 4'd0;
            cnt_en_r <= 1'b0;
            updown_r <= 1'b1;
        end else begin
            hold_r   <= hold_nxt_s;
            div_r    <= div_nxt_s;
            cnt_en_r <= step_s;
            if (step_s) begin
                updown_r <= dir_s;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Fire FSM
    // ------------------------------------------------------------------------
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SHOT    = 2'd1,
        COOL    = 2'd2,
        RELEASE = 2'd3
    } fire_state_t;

    fire_state_t state_r;
    fire_state_t state_nxt_s;
    logic [5:0]  cool_r;
    logic [5:0]  cool_nxt_s;
    logic        fire_s;
    logic        shot_r;
    logic        fire_ready_r;

    assign fire_s = deb_r[2];

    // Fire FSM next-state and cooldown counter update
    always_comb begin
        state_nxt_s = state_r;
        cool_nxt_s  = cool_r;
        case (state_r)
            IDLE: begin
                if (fire_s) begin
                    state_nxt_s = SHOT;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            SHOT: begin
                state_nxt_s = COOL;
                cool_nxt_s  = 6'd0;
            end
            COOL: begin
                if (frame_tick) begin
                    if (cool_r == COOL_LAST) begin
                        state_nxt_s = RELEASE;
                        cool_nxt_s  = 6'd0;
                    end else begin
                        cool_nxt_s  = cool_r + 6'd1;
                    end
                end else begin
                    cool_nxt_s = cool_r;
                end
            end
            RELEASE: begin
                if (!fire_s) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = RELEASE;
                end
            end
            default: begin
                state_nxt_s = IDLE;
                cool_nxt_s  = 6'd0;
            end
        endcase
    end

    // Fire FSM state register; outputs are registered from the next state so
    // they line up with the state they describe
    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_r      <= IDLE;
            cool_r       <= 6'd0;
            shot_r       <= 1'b0;
            fire_ready_r <= 1'b1;
        end else begin
            state_r      <= state_nxt_s;
            cool_r       <= cool_nxt_s;
            shot_r       <= (state_nxt_s == SHOT);
            fire_ready_r <= (state_nxt_s == IDLE);
        end
    end

    assign cnt_en     = cnt_en_r;
    assign updown     = updown_r;
    assign shot       = shot_r;
    assign fire_ready = fire_ready_r;

endmodule

// File: tb/tb_mira_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mira_ctrl : self-checking bench for mira_ctrl.
// Expected steps and shots are pushed to scoreboard queues (with the cycle in
// which they must appear) as stimulus is driven; a negedge monitor pops and
// compares them against cnt_en/updown/shot every cycle.
// -----------------------------------------------------------------------------
module tb_mira_ctrl;

    localparam int DEB  = 4;
    localparam int SLOW = 4;
    localparam int HOLD = 8;
    localparam int COOL = 3;
    // Edges from driving a button until its debounced value changes
    localparam int PRESS_LAT = 2 + DEB;

    logic clk        = 1'b0;
    logic nrst       = 1'b0;
    logic btn_left   = 1'b0;
    logic btn_right  = 1'b0;
    logic btn_fire   = 1'b0;
    logic frame_tick = 1'b0;
    logic cnt_en;
    logic updown;
    logic shot;
    logic fire_ready;

    mira_ctrl #(
        .DEB_CYCLES (DEB),
        .SLOW_DIV   (SLOW),
        .HOLD_FRAMES(HOLD),
        .COOL_FRAMES(COOL)
    ) dut (
        .clk       (clk),
        .nrst      (nrst),
        .btn_left  (btn_left),
        .btn_right (btn_right),
        .btn_fire  (btn_fire),
        .frame_tick(frame_tick),
        .cnt_en    (cnt_en),
        .updown    (updown),
        .shot      (shot),
        .fire_ready(fire_ready)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        int   cyc;
        logic dir;
    } step_t;

    step_t step_q[$];
    int    shot_q[$];

    task automatic check_eq(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Scoreboard monitor: every cycle, cnt_en/shot must be high exactly when the
    // front of the respective queue is due
    always @(negedge clk) begin : monitor
        bit exp_en;
        bit exp_shot;
        exp_en   = (step_q.size() > 0) && (step_q[0].cyc == cyc);
        exp_shot = (shot_q.size() > 0) && (shot_q[0] == cyc);
        check_eq("cnt_en", int'(cnt_en), int'(exp_en));
        if (exp_en) begin
            check_eq("updown", int'(updown), int'(step_q[0].dir));
            void'(step_q.pop_front());
        end
        check_eq("shot", int'(shot), int'(exp_shot));
        if (exp_shot) begin
            void'(shot_q.pop_front());
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drive a one-cycle tick sampled at the next edge; queue the step if one is expected
    task automatic pulse_tick(input bit step, input bit dir);
        frame_tick = 1'b1;
        if (step) step_q.push_back(step_t'{cyc: cyc + 1, dir: dir});
        wait_cyc(1);
        frame_tick = 1'b0;
    endtask

    // One 20-cycle frame ending in a tick
    task automatic frame(input bit step, input bit dir);
        wait_cyc(19);
        pulse_tick(step, dir);
    endtask

    // Does tick n (1-based) of a continuous hold step?
    function automatic bit hold_step(input int n);
        if (n <= 1) return 1'b1;
        if (n > HOLD) return 1'b1;
        return ((n - 1) % SLOW) == 0;
    endfunction

    task automatic press_fire_expect_shot();
        btn_fire = 1'b1;
        shot_q.push_back(cyc + PRESS_LAT + 1);
        wait_cyc(PRESS_LAT + 1);
        btn_fire = 1'b0;
    endtask

    initial begin
        // Reset state
        nrst = 1'b0;
        wait_cyc(3);
        check_eq("rst_cnt_en", int'(cnt_en), 0);
        check_eq("rst_updown", int'(updown), 1);
        check_eq("rst_shot", int'(shot), 0);
        check_eq("rst_fire_ready", int'(fire_ready), 1);
        nrst = 1'b1;
        wait_cyc(2);

        // Bounce on right with a tick in the middle: nothing may move
        for (int i = 0; i < 10; i++) begin
            btn_right = (i % 2 == 0);
            if (i == 5) frame_tick = 1'b1;
            wait_cyc(1);
            frame_tick = 1'b0;
            wait_cyc(1);
        end
        // Final rise: debounced after 6 edges, so a tick on edge 6 sees nothing
        // and a tick on edge 7 is the first tick of the hold
        btn_right = 1'b1;
        wait_cyc(5);
        pulse_tick(1'b0, 1'b1);
        pulse_tick(1'b1, 1'b1);

        // Slow then fast hold: steps on ticks 1,5,9,10,11,12
        for (int n = 2; n <= 12; n++) frame(hold_step(n), 1'b1);
        btn_right = 1'b0;
        frame(1'b0, 1'b0);

        // Left, both, right, then direct reversal back to left
        btn_left = 1'b1;
        frame(1'b1, 1'b0);
        frame(1'b0, 1'b0);
        btn_right = 1'b1;
        frame(1'b0, 1'b0);
        btn_left = 1'b0;
        frame(1'b1, 1'b1);
        frame(1'b0, 1'b1);
        btn_right = 1'b0;
        btn_left  = 1'b1;
        frame(1'b1, 1'b0);
        btn_left = 1'b0;
        frame(1'b0, 1'b0);

        // Fire held for 10 frames: a single shot, ready stays low until release
        btn_fire = 1'b1;
        shot_q.push_back(cyc + PRESS_LAT + 1);
        wait_cyc(PRESS_LAT);
        check_eq("ready_pre_shot", int'(fire_ready), 1);
        wait_cyc(1);
        check_eq("ready_shot", int'(fire_ready), 0);
        for (int n = 0; n < 10; n++) frame(1'b0, 1'b0);
        check_eq("ready_hold", int'(fire_ready), 0);
        btn_fire = 1'b0;
        wait_cyc(PRESS_LAT);
        check_eq("ready_pre_release", int'(fire_ready), 0);
        wait_cyc(1);
        check_eq("ready_released", int'(fire_ready), 1);

        // Second shot, then a re-press inside the cooldown must not fire;
        // ready returns exactly one cycle after the third cooldown tick
        press_fire_expect_shot();
        frame(1'b0, 1'b0);
        btn_fire = 1'b1;
        frame(1'b0, 1'b0);
        check_eq("ready_cool", int'(fire_ready), 0);
        btn_fire = 1'b0;
        frame(1'b0, 1'b0);
        check_eq("ready_cool_end", int'(fire_ready), 0);
        wait_cyc(1);
        check_eq("ready_after_cool", int'(fire_ready), 1);
        wait_cyc(3);
        press_fire_expect_shot();
        wait_cyc(10);

        // Saturated left hold plus a shot in cooldown, then reset coinciding with a tick
        btn_left = 1'b1;
        for (int n = 1; n <= 9; n++) frame(hold_step(n), 1'b0);
        press_fire_expect_shot();
        wait_cyc(2);
        nrst       = 1'b0;
        frame_tick = 1'b1;
        wait_cyc(1);
        frame_tick = 1'b0;
        check_eq("rst_mid_cnt_en", int'(cnt_en), 0);
        check_eq("rst_mid_shot", int'(shot), 0);
        check_eq("rst_mid_updown", int'(updown), 1);
        check_eq("rst_mid_fire_ready", int'(fire_ready), 1);
        wait_cyc(2);
        nrst = 1'b1;
        // Left still held: debounce restarts, then an immediate step
        wait_cyc(5);
        pulse_tick(1'b0, 1'b0);
        pulse_tick(1'b1, 1'b0);
        frame(1'b0, 1'b0);
        btn_left = 1'b0;
        frame(1'b0, 1'b0);
        // Fire FSM back in IDLE after reset
        press_fire_expect_shot();
        wait_cyc(20);

        check_eq("step_q_drained", step_q.size(), 0);
        check_eq("shot_q_drained", shot_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
